dda_stepper: RTL and testbench
==============================

Name: dda_stepper

Overview:
- Consumer of the per-column ray setup: accepts start cell, step directions, initial side distances and delta distances for one screen column.
- Walks the map grid cell by cell (DDA) until it hits a non-zero map cell, leaves the grid, or exceeds a step budget.
- Reads the map from a fixed-latency BRAM port and emits the perpendicular wall distance, hit side, wall type and hit cell to the column renderer.

Parameters:
- MAP_SIZE, 24, map is MAP_SIZE x MAP_SIZE cells; cell coordinates are 0..MAP_SIZE-1.
- MAP_DATA_WIDTH, 4, bits per map cell; 0 = empty, non-zero = wall type.
- MAP_LATENCY, 2, cycles from map_addr_out to valid map_data_in (>=1).
- MAX_STEPS, 64, step budget per ray.
- ADDR_WIDTH, $clog2(MAP_SIZE*MAP_SIZE), map address width.

Ports:
- pixel_clk_in input 1 clock.
- rst_in input 1 reset, asynchronous, active-high.
- ray_valid_in input 1 ray parameters valid.
- ray_ready_out output 1 block can accept a ray.
- hcount_in input 9 screen column tag.
- mapX_in, mapY_in input 7 start cell.
- stepX_in, stepY_in input 1 direction per axis: 1 = +1, 0 = -1.
- sideDistX_in, sideDistY_in input 16 unsigned Q8.8 distance to first boundary.
- deltaDistX_in, deltaDistY_in input 16 unsigned Q8.8 distance between boundaries.
- map_addr_out output ADDR_WIDTH cell address, mapY*MAP_SIZE+mapX.
- map_data_in input MAP_DATA_WIDTH cell contents.
- hit_valid_out output 1 result valid.
- hit_ready_in input 1 downstream accepts result.
- hcount_out output 9 column tag of result.
- perpWallDist_out output 16 unsigned Q8.8 perpendicular distance.
- side_out output 1 0 = X-side hit, 1 = Y-side hit.
- wall_type_out output MAP_DATA_WIDTH map value at hit cell (0 on out-of-bounds or timeout).
- hitX_out, hitY_out output 7 hit cell.
- oob_out output 1 ray left the grid.
- timeout_out output 1 MAX_STEPS exhausted.

Behaviour:
- Reset: all outputs 0, except ray_ready_out = 1. Internal state returns to IDLE. Reset asserted mid-ray aborts the ray, and no result is emitted.
- States are IDLE, STEP, WAIT, CHECK, DONE.
- IDLE:
  - ray_ready_out = 1.
  - On ray_valid_in & ray_ready_out, capture all inputs, clear the step counter, go to STEP.
  - ray_ready_out is 0 in every other state.
- STEP (1 cycle):
  - If sideDistX < sideDistY, then mapX += step (±1), sideDistX += deltaDistX, side = 0.
  - Otherwise (ties included), step Y the same way with side = 1.
  - Sums saturate at 0xFFFF.
  - Step counter increments.
  - If the new cell is outside 0..MAP_SIZE-1 (including wrap below 0), set oob and go to DONE without a map read.
  - Otherwise drive map_addr_out for the new cell (registered) and go to WAIT.
- WAIT: hold map_addr_out for MAP_LATENCY cycles, then go to CHECK.
- CHECK (1 cycle):
  - If map_data_in != 0, latch the wall type and go to DONE.
  - Else if the step counter == MAX_STEPS, set timeout and go to DONE.
  - Else go to STEP.
- Latency: a ray resolving after N in-grid steps enters DONE N*(MAP_LATENCY+2) cycles after acceptance. An out-of-bounds exit adds 1 cycle after the last in-grid step.
- DONE:
  - Output registers load on entry. hit_valid_out = 1 and all outputs are held stable until hit_valid_out & hit_ready_in.
  - After that handshake, hit_valid_out drops the next cycle and the state returns to IDLE.
  - Back-to-back throughput is therefore one ray per (latency + 2) cycles.
- Distance: perpWallDist_out = side ? sideDistY - deltaDistY : sideDistX - deltaDistX, clamped at 0. It is computed on every termination cause.
- hitX_out/hitY_out are the final cell, which may be out of range when oob_out = 1.
- A new ray is never accepted while a result is pending.

Optional Feature:
- Macro DDA_STEP_COUNT_EN.
- When defined: extra output port step_count_out (width $clog2(MAX_STEPS+1)) carrying the number of steps taken, valid with hit_valid_out, and reset to 0.
- When undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- Basic X hit (MAP_LATENCY=2):
  - Stimulus: start (5,5), stepX=1, sideDistX=0x0080, deltaDistX=0x0100, sideDistY=deltaDistY=0x7F00, wall type 3 at (7,5).
  - Required response: hit_valid_out 8 cycles after acceptance; hitX=7, hitY=5, side=0, perpWallDist=0x0180, wall_type=3; step_count=2 if enabled.
- Tie break:
  - Stimulus: sideDistX=sideDistY=0x0100, deltaDist both 0x0100, stepY=0, wall at (mapX, mapY-1).
  - Required response: side=1, hitY=mapY-1, perpWallDist=0x0100.
- Out of bounds:
  - Stimulus: start (0,3), stepX=0, empty map, X-dominant distances.
  - Required response: oob_out=1, wall_type=0 after the first step; no map read issued for the out-of-range cell.
- Timeout and saturation:
  - Stimulus: MAX_STEPS=4, empty map, sideDistX=0xFF00, deltaDistX=0x0200, sideDistY=0xFFFF.
  - Required response: timeout_out=1 after 4 steps; sideDistX saturates at 0xFFFF; outputs stable.
- Backpressure:
  - Stimulus: hold hit_ready_in=0 for 10 cycles after hit_valid_out.
  - Required response: all outputs unchanged and ray_ready_out=0; one cycle after release, hit_valid_out=0 and ray_ready_out=1.
- Reset mid-ray:
  - Stimulus: assert rst_in asynchronously during WAIT.
  - Required response: all outputs 0 and ray_ready_out=1 immediately; no stale result after release; the next ray completes correctly.

Source files
------------

// File: rtl/dda_stepper.sv
`default_nettype none
// ============================================================================
// Module   : dda_stepper
// Purpose  : Per-column DDA grid walker. Accepts one ray setup, steps through
//            the map cell by cell reading a fixed-latency BRAM port, and
//            reports the perpendicular wall distance, hit side, wall type and
//            hit cell. A ray also ends when it leaves the grid or when its
//            step budget runs out.
// Options  : DDA_STEP_COUNT_EN - adds the step_count_out result port.
// Revision : 1.0 - initial release
// ============================================================================
module dda_stepper #(
    parameter int MAP_SIZE       = 24,
    parameter int MAP_DATA_WIDTH = 4,
    parameter int MAP_LATENCY    = 2,
    parameter int MAX_STEPS      = 64,
    parameter int ADDR_WIDTH     = $clog2(MAP_SIZE*MAP_SIZE)
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_in,
    // ray setup
    input  logic                      ray_valid_in,
    output logic                      ray_ready_out,
    input  logic [8:0]                hcount_in,
    input  logic [6:0]                mapX_in,
    input  logic [6:0]                mapY_in,
    input  logic                      stepX_in,
    input  logic                      stepY_in,
    input  logic [15:0]               sideDistX_in,
    input  logic [15:0]               sideDistY_in,
    input  logic [15:0]               deltaDistX_in,
    input  logic [15:0]               deltaDistY_in,
    // map BRAM port
    output logic [ADDR_WIDTH-1:0]     map_addr_out,
    input  logic [MAP_DATA_WIDTH-1:0] map_data_in,
    // result
    output logic                      hit_valid_out,
    input  logic                      hit_ready_in,
    output logic [8:0]                hcount_out,
    output logic [15:0]               perpWallDist_out,
    output logic                      side_out,
    output logic [MAP_DATA_WIDTH-1:0] wall_type_out,
    output logic [6:0]                hitX_out,
    output logic [6:0]                hitY_out,
    output logic                      oob_out,
    output logic                      timeout_out
`ifdef DDA_STEP_COUNT_EN
    ,
    output logic [$clog2(MAX_STEPS+1)-1:0] step_count_out
`endif
);

    localparam int c_CNT_W  = $clog2(MAX_STEPS+1);
    localparam int c_WAIT_W = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(MAX_STEPS);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAP_LATENCY-1);
    localparam logic [6:0]          c_MAP_LIM   = 7'(MAP_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // captured ray state
    logic [6:0]          r_map_x, r_map_y;
    logic                r_step_x, r_step_y;
    logic [15:0]         r_side_dist_x, r_side_dist_y;
    logic [15:0]         r_delta_x, r_delta_y;
    logic [8:0]          r_hcount;
    logic                r_side;
    logic [c_CNT_W-1:0]  r_step_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_map_addr;

    // result registers
    logic                      r_hit_valid;
    logic [8:0]                r_hcount_out;
    logic [15:0]               r_perp;
    logic                      r_side_out;
    logic [MAP_DATA_WIDTH-1:0] r_wall_type;
    logic [6:0]                r_hit_x, r_hit_y;
    logic                      r_oob, r_timeout;

    // single-step datapath
    logic                  w_take_x;
    logic [6:0]            w_adv_x, w_adv_y;
    logic [16:0]           w_sum_x, w_sum_y;
    logic [15:0]           w_sat_x, w_sat_y;
    logic [6:0]            w_new_map_x, w_new_map_y;
    logic [15:0]           w_new_sd_x, w_new_sd_y;
    logic                  w_new_side;
    logic                  w_oob;
    logic [ADDR_WIDTH-1:0] w_new_addr;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_map_hit;
    logic                  w_ray_ready;
    logic                  w_done_from_step;
    logic                  w_done_from_check;

    // Distance back to the last crossed boundary, clamped so a saturated
    // accumulator can never produce a negative (wrapped) distance.
    function automatic logic [15:0] f_perp(input logic side,
                                           input logic [15:0] sx, input logic [15:0] dx,
                                           input logic [15:0] sy, input logic [15:0] dy);
        logic [15:0] a;
        logic [15:0] b;
        a = side ? sy : sx;
        b = side ? dy : dx;
        return (a > b) ? (a - b) : 16'd0;
    endfunction

    // Candidate next cell and distances; ties go to the Y axis.
    always_comb begin
        w_take_x    = (r_side_dist_x < r_side_dist_y);
        w_adv_x     = r_step_x ? (r_map_x + 7'd1) : (r_map_x - 7'd1);
        w_adv_y     = r_step_y ? (r_map_y + 7'd1) : (r_map_y - 7'd1);
        w_sum_x     = {1'b0, r_side_dist_x} + {1'b0, r_delta_x};
        w_sum_y     = {1'b0, r_side_dist_y} + {1'b0, r_delta_y};
        w_sat_x     = w_sum_x[16] ? 16'hFFFF : w_sum_x[15:0];
        w_sat_y     = w_sum_y[16] ? 16'hFFFF : w_sum_y[15:0];
        w_new_map_x = w_take_x ? w_adv_x : r_map_x;
        w_new_map_y = w_take_x ? r_map_y : w_adv_y;
        w_new_sd_x  = w_take_x ? w_sat_x : r_side_dist_x;
        w_new_sd_y  = w_take_x ? r_side_dist_y : w_sat_y;
        w_new_side  = ~w_take_x;
        // stepping below 0 wraps to 127, so one unsigned compare covers both ends
        w_oob       = (w_new_map_x >= c_MAP_LIM) || (w_new_map_y >= c_MAP_LIM);
        w_new_addr  = ADDR_WIDTH'(w_new_map_y) * ADDR_WIDTH'(MAP_SIZE) + ADDR_WIDTH'(w_new_map_x);
        w_cnt_inc   = r_step_cnt + c_CNT_ONE;
        w_map_hit   = (map_data_in != '0);
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_ray_ready       = 1'b0;
        w_done_from_step  = 1'b0;
        w_done_from_check = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ray_ready = 1'b1;
                if (ray_valid_in) w_state_nxt = S_STEP;
            end
            S_STEP: begin
                if (w_oob) begin
                    w_state_nxt      = S_DONE;
                    w_done_from_step = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_map_hit || (r_step_cnt == c_CNT_MAX)) begin
                    w_state_nxt       = S_DONE;
                    w_done_from_check = 1'b1;
                end else begin
                    w_state_nxt = S_STEP;
                end
            end
            S_DONE: begin
                if (hit_ready_in) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Ray capture, stepping, and map address generation.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_map_x       <= '0;
            r_map_y       <= '0;
            r_step_x      <= 1'b0;
            r_step_y      <= 1'b0;
            r_side_dist_x <= '0;
            r_side_dist_y <= '0;
            r_delta_x     <= '0;
            r_delta_y     <= '0;
            r_hcount      <= '0;
            r_side        <= 1'b0;
            r_step_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_map_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ray_valid_in) begin
                        r_map_x       <= mapX_in;
                        r_map_y       <= mapY_in;
                        r_step_x      <= stepX_in;
                        r_step_y      <= stepY_in;
                        r_side_dist_x <= sideDistX_in;
                        r_side_dist_y <= sideDistY_in;
                        r_delta_x     <= deltaDistX_in;
                        r_delta_y     <= deltaDistY_in;
                        r_hcount      <= hcount_in;
                        r_step_cnt    <= '0;
                    end
                end
                S_STEP: begin
                    r_map_x       <= w_new_map_x;
                    r_map_y       <= w_new_map_y;
                    r_side_dist_x <= w_new_sd_x;
                    r_side_dist_y <= w_new_sd_y;
                    r_side        <= w_new_side;
                    r_step_cnt    <= w_cnt_inc;
                    r_wait_cnt    <= '0;
                    // an out-of-range cell is never presented to the BRAM
                    if (!w_oob) r_map_addr <= w_new_addr;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Result registers: load on entry to DONE, hold until accepted.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hit_valid  <= 1'b0;
            r_hcount_out <= '0;
            r_perp       <= '0;
            r_side_out   <= 1'b0;
            r_wall_type  <= '0;
            r_hit_x      <= '0;
            r_hit_y      <= '0;
            r_oob        <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (w_done_from_step) begin
            r_hit_valid  <= 1'b1;
            r_hcount_out <= r_hcount;
            r_perp       <= f_perp(w_new_side, w_new_sd_x, r_delta_x, w_new_sd_y, r_delta_y);
            r_side_out   <= w_new_side;
            r_wall_type  <= '0;
            r_hit_x      <= w_new_map_x;
            r_hit_y      <= w_new_map_y;
            r_oob        <= 1'b1;
            r_timeout    <= 1'b0;
        end else if (w_done_from_check) begin
            r_hit_valid  <= 1'b1;
            r_hcount_out <= r_hcount;
            r_perp       <= f_perp(r_side, r_side_dist_x, r_delta_x, r_side_dist_y, r_delta_y);
            r_side_out   <= r_side;
            r_wall_type  <= w_map_hit ? map_data_in : '0;
            r_hit_x      <= r_map_x;
            r_hit_y      <= r_map_y;
            r_oob        <= 1'b0;
            r_timeout    <= ~w_map_hit;
        end else if ((r_state == S_DONE) && hit_ready_in) begin
            r_hit_valid  <= 1'b0;
        end
    end

`ifdef DDA_STEP_COUNT_EN
    logic [c_CNT_W-1:0] r_step_count_out;

    // Step count reported alongside the result.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in)                 r_step_count_out <= '0;
        else if (w_done_from_step)  r_step_count_out <= w_cnt_inc;
        else if (w_done_from_check) r_step_count_out <= r_step_cnt;
    end

    assign step_count_out = r_step_count_out;
`endif

    assign ray_ready_out    = w_ray_ready;
    assign map_addr_out     = r_map_addr;
    assign hit_valid_out    = r_hit_valid;
    assign hcount_out       = r_hcount_out;
    assign perpWallDist_out = r_perp;
    assign side_out         = r_side_out;
    assign wall_type_out    = r_wall_type;
    assign hitX_out         = r_hit_x;
    assign hitY_out         = r_hit_y;
    assign oob_out          = r_oob;
    assign timeout_out      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dda_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_dda_stepper
// Purpose  : Directed bench for dda_stepper with a behavioural map BRAM.
//            Set DDA_STEP_COUNT_EN to also check step_count_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dda_stepper;

    localparam int MS   = 24;
    localparam int LAT  = 2;
    localparam int MAXS = 4;
    localparam int AW   = $clog2(MS*MS);

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          ray_valid = 1'b0;
    logic          ray_ready;
    logic [8:0]    hcount_in = '0;
    logic [6:0]    map_x_in = '0, map_y_in = '0;
    logic          step_x_in = 1'b0, step_y_in = 1'b0;
    logic [15:0]   sd_x_in = '0, sd_y_in = '0, dd_x_in = '0, dd_y_in = '0;
    logic [AW-1:0] map_addr;
    logic [3:0]    map_data;
    logic          hit_valid;
    logic          hit_ready = 1'b0;
    logic [8:0]    hcount_out;
    logic [15:0]   perp;
    logic          side;
    logic [3:0]    wall_type;
    logic [6:0]    hit_x, hit_y;
    logic          oob, timeout;
`ifdef DDA_STEP_COUNT_EN
    logic [$clog2(MAXS+1)-1:0] step_count;
`endif

    dda_stepper #(
        .MAP_SIZE(MS), .MAP_DATA_WIDTH(4), .MAP_LATENCY(LAT), .MAX_STEPS(MAXS)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst_in),
        .ray_valid_in(ray_valid), .ray_ready_out(ray_ready),
        .hcount_in(hcount_in), .mapX_in(map_x_in), .mapY_in(map_y_in),
        .stepX_in(step_x_in), .stepY_in(step_y_in),
        .sideDistX_in(sd_x_in), .sideDistY_in(sd_y_in),
        .deltaDistX_in(dd_x_in), .deltaDistY_in(dd_y_in),
        .map_addr_out(map_addr), .map_data_in(map_data),
        .hit_valid_out(hit_valid), .hit_ready_in(hit_ready),
        .hcount_out(hcount_out), .perpWallDist_out(perp), .side_out(side),
        .wall_type_out(wall_type), .hitX_out(hit_x), .hitY_out(hit_y),
        .oob_out(oob), .timeout_out(timeout)
`ifdef DDA_STEP_COUNT_EN
        , .step_count_out(step_count)
`endif
    );

    always #5 clk = ~clk;

    // map BRAM model: LAT register stages from address to data
    logic [3:0] map_mem [0:MS*MS-1];
    logic [3:0] bram_d1, bram_d2;
    always @(posedge clk) begin
        bram_d1 <= (int'(map_addr) < MS*MS) ? map_mem[map_addr] : 4'd0;
        bram_d2 <= bram_d1;
    end
    assign map_data = bram_d2;

    wire [45:0] outs = {hcount_out, perp, side, wall_type, hit_x, hit_y, oob, timeout};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [6:0]  mx, my;
        logic        dxs, dys;
        logic [15:0] sdx, sdy, ddx, ddy;
        logic [6:0]  wx, wy;
        logic [3:0]  wt;
        logic [8:0]  hc;
        logic [6:0]  ex, ey;
        logic        eside;
        logic [15:0] eperp;
        logic [3:0]  ewt;
        logic        eoob, eto;
        logic [7:0]  elat, esteps;
        logic        noread;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    // set up the map for one ray and perform the acceptance handshake
    task automatic start_ray(input vec_t v);
        for (int i = 0; i < MS*MS; i++) map_mem[i] = 4'd0;
        if (v.wt != 0) map_mem[int'(v.wy)*MS + int'(v.wx)] = v.wt;
        map_x_in = v.mx; map_y_in = v.my;
        step_x_in = v.dxs; step_y_in = v.dys;
        sd_x_in = v.sdx; sd_y_in = v.sdy; dd_x_in = v.ddx; dd_y_in = v.ddy;
        hcount_in = v.hc;
        ray_valid = 1'b1;
        @(posedge clk); #1;
        ray_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        logic moved;
        logic [AW-1:0] addr0;
        check($sformatf("v%0d ready_before", idx), 64'(ray_ready), 64'd1);
        addr0 = map_addr;
        start_ray(v);
        cyc = 0;
        moved = 1'b0;
        while (!hit_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (map_addr != addr0) moved = 1'b1;
        end
        check($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.elat));
        check($sformatf("v%0d hitX", idx), 64'(hit_x), 64'(v.ex));
        check($sformatf("v%0d hitY", idx), 64'(hit_y), 64'(v.ey));
        check($sformatf("v%0d side", idx), 64'(side), 64'(v.eside));
        check($sformatf("v%0d perp", idx), 64'(perp), 64'(v.eperp));
        check($sformatf("v%0d wall", idx), 64'(wall_type), 64'(v.ewt));
        check($sformatf("v%0d oob", idx), 64'(oob), 64'(v.eoob));
        check($sformatf("v%0d timeout", idx), 64'(timeout), 64'(v.eto));
        check($sformatf("v%0d hcount", idx), 64'(hcount_out), 64'(v.hc));
        check($sformatf("v%0d ready_busy", idx), 64'(ray_ready), 64'd0);
`ifdef DDA_STEP_COUNT_EN
        check($sformatf("v%0d steps", idx), 64'(step_count), 64'(v.esteps));
`endif
        if (v.noread) check($sformatf("v%0d no_map_read", idx), 64'(moved), 64'd0);
        hit_ready = 1'b1;
        @(posedge clk); #1;
        hit_ready = 1'b0;
        check($sformatf("v%0d valid_drop", idx), 64'(hit_valid), 64'd0);
        check($sformatf("v%0d ready_after", idx), 64'(ray_ready), 64'd1);
    endtask

    initial begin
        //          mx    my    dx    dy    sdx       sdy       ddx       ddy       wx     wy     wt    hc      ex      ey     side  perp      ewt   oob   to    lat   steps noread
        vecs[0] = '{7'd5, 7'd5, 1'b1, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00, 7'd7,  7'd5,  4'd3, 9'd10,  7'd7,   7'd5,  1'b0, 16'h0180, 4'd3, 1'b0, 1'b0, 8'd8,  8'd2, 1'b0};
        vecs[1] = '{7'd5, 7'd5, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 7'd5,  7'd4,  4'd5, 9'd11,  7'd5,   7'd4,  1'b1, 16'h0100, 4'd5, 1'b0, 1'b0, 8'd4,  8'd1, 1'b0};
        vecs[2] = '{7'd0, 7'd3, 1'b0, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00, 7'd0,  7'd0,  4'd0, 9'd12,  7'd127, 7'd3,  1'b0, 16'h0080, 4'd0, 1'b1, 1'b0, 8'd1,  8'd1, 1'b1};
        vecs[3] = '{7'd10,7'd10,1'b1, 1'b1, 16'hFF00, 16'hFFFF, 16'h0200, 16'h0100, 7'd0,  7'd0,  4'd0, 9'd13,  7'd11,  7'd13, 1'b1, 16'hFEFF, 4'd0, 1'b0, 1'b1, 8'd16, 8'd4, 1'b0};
        vecs[4] = '{7'd1, 7'd3, 1'b0, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00, 7'd0,  7'd0,  4'd0, 9'd14,  7'd127, 7'd3,  1'b0, 16'h0180, 4'd0, 1'b1, 1'b0, 8'd5,  8'd2, 1'b0};
        vecs[5] = '{7'd4, 7'd23,1'b1, 1'b1, 16'h7F00, 16'h0040, 16'h7F00, 16'h0100, 7'd0,  7'd0,  4'd0, 9'd300, 7'd4,   7'd24, 1'b1, 16'h0040, 4'd0, 1'b1, 1'b0, 8'd1,  8'd1, 1'b1};
        vecs[6] = '{7'd2, 7'd2, 1'b1, 1'b1, 16'h0100, 16'h0180, 16'h0200, 16'h0200, 7'd3,  7'd3,  4'd7, 9'd15,  7'd3,   7'd3,  1'b1, 16'h0180, 4'd7, 1'b0, 1'b0, 8'd8,  8'd2, 1'b0};
        vecs[7] = '{7'd20,7'd20,1'b0, 1'b0, 16'h0300, 16'h0080, 16'h0400, 16'h0100, 7'd20, 7'd17, 4'd15,9'd511, 7'd20,  7'd17, 1'b1, 16'h0280, 4'd15,1'b0, 1'b0, 8'd12, 8'd3, 1'b0};
        vecs[8] = '{7'd10,7'd10,1'b1, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00, 7'd14, 7'd10, 4'd2, 9'd16,  7'd14,  7'd10, 1'b0, 16'h0380, 4'd2, 1'b0, 1'b0, 8'd16, 8'd4, 1'b0};

        for (int i = 0; i < MS*MS; i++) map_mem[i] = 4'd0;

        // reset state
        #2;
        check("reset ready", 64'(ray_ready), 64'd1);
        check("reset valid", 64'(hit_valid), 64'd0);
        check("reset addr", 64'(map_addr), 64'd0);
        check("reset outs", 64'(outs), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_in = 1'b0;
        @(posedge clk); #1;
        check("post-reset ready", 64'(ray_ready), 64'd1);
`ifdef DDA_STEP_COUNT_EN
        check("reset steps", 64'(step_count), 64'd0);
`endif

        // table-driven rays
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // backpressure: result held for 10 cycles with ready low
        begin
            logic [45:0] snap;
            int cyc;
            start_ray(vecs[0]);
            cyc = 0;
            while (!hit_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
            check("bp valid", 64'(hit_valid), 64'd1);
            snap = outs;
            check("bp snap perp", 64'(perp), 64'h0180);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                check($sformatf("bp hold%0d outs", k), 64'(outs), 64'(snap));
                check($sformatf("bp hold%0d valid", k), 64'(hit_valid), 64'd1);
                check($sformatf("bp hold%0d ready", k), 64'(ray_ready), 64'd0);
            end
            hit_ready = 1'b1;
            @(posedge clk); #1;
            hit_ready = 1'b0;
            check("bp release valid", 64'(hit_valid), 64'd0);
            check("bp release ready", 64'(ray_ready), 64'd1);
        end

        // asynchronous reset during WAIT
        begin
            logic seen;
            start_ray(vecs[0]);
            @(posedge clk); #1;
            check("mid addr before rst", 64'(map_addr), 64'(5*MS+6));
            #2 rst_in = 1'b1;
            #1;
            check("mid rst ready", 64'(ray_ready), 64'd1);
            check("mid rst valid", 64'(hit_valid), 64'd0);
            check("mid rst addr", 64'(map_addr), 64'd0);
            check("mid rst outs", 64'(outs), 64'd0);
            @(negedge clk);
            rst_in = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (hit_valid) seen = 1'b1;
            end
            check("mid rst no stale result", 64'(seen), 64'd0);
            run_vec(vecs[1], 100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
